// File: rtl/vpi_value_change_monitor.sv
// Multi-channel value-change monitor: timestamps per-channel changes, coalesces
// repeats while pending, and queues events in a first-word-fall-through FIFO.
module vpi_value_change_monitor #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned TIME_WIDTH   = 32,
  parameter int unsigned CNT_WIDTH    = 16,
  localparam int unsigned CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int unsigned LVL_W       = $clog2(DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CHANNELS-1:0]            enable,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] sig_in,
  output logic                               evt_valid,
  input  logic                               evt_ready,
  output logic [CH_W-1:0]                    evt_channel,
  output logic [DATA_WIDTH-1:0]              evt_value,
  output logic [TIME_WIDTH-1:0]              evt_time,
  output logic [LVL_W-1:0]                   fifo_level,
  output logic [CNT_WIDTH-1:0]               drop_count,
  input  logic                               clear_drops
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned SUM_W = CNT_WIDTH + 6;

  logic [TIME_WIDTH-1:0]   r_time;
  logic [NUM_CHANNELS-1:0] r_primed;
  logic [NUM_CHANNELS-1:0] r_pending;
  logic [DATA_WIDTH-1:0]   r_prev  [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   r_pval  [NUM_CHANNELS];
  logic [TIME_WIDTH-1:0]   r_ptime [NUM_CHANNELS];

  logic [CH_W-1:0]         r_mem_ch   [DEPTH];
  logic [DATA_WIDTH-1:0]   r_mem_val  [DEPTH];
  logic [TIME_WIDTH-1:0]   r_mem_time [DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [LVL_W-1:0]        r_count;
  logic                    r_full;
  logic [CNT_WIDTH-1:0]    r_drops;

  logic [DATA_WIDTH-1:0]   w_sig [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] w_change;
  logic [NUM_CHANNELS-1:0] w_take;
  logic [NUM_CHANNELS-1:0] w_coal;
  logic                    w_found;
  logic                    w_push;
  logic                    w_pop;
  logic [CH_W-1:0]         w_push_ch;
  logic [LVL_W-1:0]        w_count_next;
  logic [SUM_W-1:0]        w_drop_inc;
  logic [SUM_W-1:0]        w_drop_sum;
  logic [CNT_WIDTH-1:0]    w_drop_next;

  // Change detection and lowest-index arbitration over pending channels
  always_comb begin
    w_found   = 1'b0;
    w_push_ch = '0;
    w_take    = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_sig[i]    = sig_in[i*DATA_WIDTH +: DATA_WIDTH];
      w_change[i] = enable[i] && r_primed[i] && (w_sig[i] != r_prev[i]);
      if (!w_found && r_pending[i] && enable[i] && !r_full) begin
        w_found   = 1'b1;
        w_push_ch = CH_W'(i);
        w_take[i] = 1'b1;
      end
    end
    w_push = w_found;
    w_coal = w_change & r_pending & ~w_take;
  end

  // Saturating drop accumulation; several channels may coalesce in one cycle
  always_comb begin
    w_drop_inc = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_drop_inc = w_drop_inc + SUM_W'(w_coal[i]);
    end
    w_drop_sum = SUM_W'(r_drops) + w_drop_inc;
    if (w_drop_sum > SUM_W'({CNT_WIDTH{1'b1}})) begin
      w_drop_next = '1;
    end else begin
      w_drop_next = w_drop_sum[CNT_WIDTH-1:0];
    end
  end

  always_comb begin
    w_pop        = (r_count != '0) && evt_ready;
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + LVL_W'(1);
      2'b01:   w_count_next = r_count - LVL_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_time    <= '0;
      r_primed  <= '0;
      r_pending <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_prev[i]  <= '0;
        r_pval[i]  <= '0;
        r_ptime[i] <= '0;
      end
    end else begin
      r_time <= r_time + TIME_WIDTH'(1);
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (!enable[i]) begin
          r_primed[i]  <= 1'b0;
          r_pending[i] <= 1'b0;
        end else if (!r_primed[i]) begin
          r_prev[i]   <= w_sig[i];
          r_primed[i] <= 1'b1;
        end else if (w_change[i]) begin
          // Fresh capture or coalesce: newest value and time always win
          r_prev[i]    <= w_sig[i];
          r_pval[i]    <= w_sig[i];
          r_ptime[i]   <= r_time;
          r_pending[i] <= 1'b1;
        end else if (w_take[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_drops  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == LVL_W'(DEPTH));
      r_drops <= clear_drops ? '0 : w_drop_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_ch[r_wr_ptr]   <= w_push_ch;
      r_mem_val[r_wr_ptr]  <= r_pval[w_push_ch];
      r_mem_time[r_wr_ptr] <= r_ptime[w_push_ch];
    end
  end

  assign evt_valid   = (r_count != '0);
  assign evt_channel = evt_valid ? r_mem_ch[r_rd_ptr]   : '0;
  assign evt_value   = evt_valid ? r_mem_val[r_rd_ptr]  : '0;
  assign evt_time    = evt_valid ? r_mem_time[r_rd_ptr] : '0;
  assign fifo_level  = r_count;
  assign drop_count  = r_drops;

endmodule

// File: tb/tb_vpi_value_change_monitor.sv
// Directed bench for vpi_value_change_monitor (4 ch, 8-bit data, DEPTH 2, 4-bit time).
module tb_vpi_value_change_monitor;

  localparam int unsigned NC = 4;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NC-1:0] enable;
  logic [DW-1:0] s [NC];
  logic [NC*DW-1:0] sig_in;
  logic          evt_valid;
  logic          evt_ready;
  logic [1:0]    evt_channel;
  logic [DW-1:0] evt_value;
  logic [3:0]    evt_time;
  logic [1:0]    fifo_level;
  logic [2:0]    drop_count;
  logic          clear_drops;

  int n_checks = 0;
  int n_fail   = 0;

  assign sig_in = {s[3], s[2], s[1], s[0]};

  always #5 clk = ~clk;

  vpi_value_change_monitor #(
    .NUM_CHANNELS(NC), .DATA_WIDTH(DW), .DEPTH(2), .TIME_WIDTH(4), .CNT_WIDTH(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_channel(evt_channel),
    .evt_value(evt_value), .evt_time(evt_time), .fifo_level(fifo_level),
    .drop_count(drop_count), .clear_drops(clear_drops)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] ch,
                          input logic [31:0] val, input logic [31:0] t);
    chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
    chk({tag, "_ch"},    32'(evt_channel), ch);
    chk({tag, "_val"},   32'(evt_value), val);
    chk({tag, "_time"},  32'(evt_time), t);
  endtask

  initial begin
    rst_n = 1'b0; enable = '0; evt_ready = 1'b0; clear_drops = 1'b0;
    for (int i = 0; i < NC; i++) s[i] = '0;
    step(2);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    chk("rst_ch",    32'(evt_channel), 32'd0);
    chk("rst_val",   32'(evt_value), 32'd0);
    chk("rst_time",  32'(evt_time), 32'd0);

    // Single change on ch0 sampled at edge 10 (T=9)
    rst_n = 1'b1; enable = 4'b0001;
    step(9);
    chk("prime_no_evt", 32'(evt_valid), 32'd0);
    s[0] = 8'h05;
    step(1);
    chk("lat_not_yet", 32'(evt_valid), 32'd0);
    step(1);
    chk_head("single", 0, 32'h05, 9);
    chk("single_level", 32'(fifo_level), 32'd1);
    evt_ready = 1'b1;
    step(1);
    chk("single_pop", 32'(evt_valid), 32'd0);

    // Simultaneous change on all channels at edge 14 (T=13)
    evt_ready = 1'b0; enable = 4'b1111;
    step(1);
    s[0] = 8'hA0; s[1] = 8'hA1; s[2] = 8'hA2; s[3] = 8'hA3; evt_ready = 1'b1;
    step(1);
    chk("burst_pending_only", 32'(evt_valid), 32'd0);
    for (int c = 0; c < NC; c++) begin
      step(1);
      chk_head("burst", 32'(c), 32'hA0 + 32'(c), 13);
    end
    step(1);
    chk("burst_empty", 32'(evt_valid), 32'd0);
    chk("burst_drops", 32'(drop_count), 32'd0);

    // Coalescing: ch0 changes at edges 20..24, FIFO of 2 fills, last value pends
    evt_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      s[0] = 8'(k);
      step(1);
    end
    chk("coal_level", 32'(fifo_level), 32'd2);
    chk("coal_drops", 32'(drop_count), 32'd2);
    chk_head("coal_h0", 0, 1, 3);
    evt_ready = 1'b1;
    step(1);
    chk_head("coal_h1", 0, 2, 4);
    step(1);
    chk_head("coal_h2", 0, 5, 7);
    step(1);
    chk("coal_empty", 32'(evt_valid), 32'd0);

    // Backpressure: head must hold for 8 cycles
    evt_ready = 1'b0;
    s[1] = 8'h55;
    step(1);
    s[2] = 8'h66;
    step(1);
    chk_head("bp_first", 1, 32'h55, 11);
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk("bp_val",  32'(evt_value), 32'h55);
      chk("bp_time", 32'(evt_time), 32'd11);
    end
    chk("bp_level", 32'(fifo_level), 32'd2);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    chk("bp_level_pop", 32'(fifo_level), 32'd1);
    chk_head("bp_next", 2, 32'h66, 12);

    // Disable discards pending ch2 while FIFO is full
    s[3] = 8'h77;
    step(1);
    s[2] = 8'h88;
    step(1);
    chk("dis_full", 32'(fifo_level), 32'd2);
    step(1);
    enable = 4'b1011;
    step(1);
    evt_ready = 1'b1;
    step(1);
    chk_head("dis_head", 3, 32'h77, 6);
    step(1);
    chk("dis_empty", 32'(evt_valid), 32'd0);
    step(1);
    chk("dis_no_ch2", 32'(evt_valid), 32'd0);
    chk("dis_drops", 32'(drop_count), 32'd2);

    // clear_drops beats a simultaneous coalesce on ch1
    s[0] = 8'h10; s[1] = 8'h20;
    step(1);
    chk("clr_before", 32'(drop_count), 32'd2);
    s[1] = 8'h21; clear_drops = 1'b1;
    step(1);
    clear_drops = 1'b0;
    chk("clr_drops", 32'(drop_count), 32'd0);
    chk_head("clr_h0", 0, 32'h10, 13);
    step(1);
    chk_head("clr_h1", 1, 32'h21, 14);
    step(1);
    chk("clr_empty", 32'(evt_valid), 32'd0);

    // Drop counter saturates at 7
    evt_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      s[0] = 8'h30 + 8'(k);
      step(1);
    end
    chk("sat_drops", 32'(drop_count), 32'd7);
    chk("sat_level", 32'(fifo_level), 32'd2);

    // Mid-stream reset, then a change at T=15 followed by one at T=0
    rst_n = 1'b0;
    step(1);
    chk("mrst_valid", 32'(evt_valid), 32'd0);
    chk("mrst_level", 32'(fifo_level), 32'd0);
    chk("mrst_drops", 32'(drop_count), 32'd0);
    rst_n = 1'b1; evt_ready = 1'b1;
    step(15);
    s[0] = 8'hE1;
    step(1);
    chk("wrap_pending", 32'(evt_valid), 32'd0);
    s[0] = 8'hE2;
    step(1);
    chk_head("wrap_15", 0, 32'hE1, 15);
    chk("wrap_level", 32'(fifo_level), 32'd1);
    step(1);
    chk_head("wrap_0", 0, 32'hE2, 0);
    step(1);
    chk("wrap_empty", 32'(evt_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vpi_value_change_monitor.md
Name: vpi_value_change_monitor

Overview:
- Synthesisable, multi-channel counterpart to the cbValueChange callback.
- Watches NUM_CHANNELS parallel signals and timestamps every value change. Changes are queued as events in an internal FIFO, drained over a valid/ready interface.
- Sits beside the DUT; the VPI-side layer drains it in place of per-signal software callbacks.
- Coalesces repeat changes while an event is pending and counts lost events.

Parameters:
- NUM_CHANNELS, 4, number of monitored signals (1..32).
- DATA_WIDTH, 32, width of each monitored signal.
- DEPTH, 16, event FIFO depth (power of two, >=2).
- TIME_WIDTH, 32, width of the cycle timestamp counter.
- CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- enable  in  NUM_CHANNELS  per-channel monitor enable.
- sig_in  in  NUM_CHANNELS*DATA_WIDTH  monitored values; channel i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts event.
- evt_channel  out  $clog2(NUM_CHANNELS) (min 1)  channel index of head event.
- evt_value  out  DATA_WIDTH  new value of head event.
- evt_time  out  TIME_WIDTH  timestamp of head event.
- fifo_level  out  $clog2(DEPTH+1)  entries held in the FIFO.
- drop_count  out  CNT_WIDTH  events lost (coalesced or overwritten).
- clear_drops  in  1  synchronous clear of drop_count.

Behaviour:
- Reset (rst_n low at an edge):
  - Clears: time counter, all prev/pending/primed state, FIFO.
  - Outputs: evt_valid=0, evt_channel/evt_value/evt_time=0, fifo_level=0, drop_count=0.
  - Applies mid-operation: queued and pending events are discarded.
- Time counter:
  - Increments by 1 every edge after reset and wraps modulo 2^TIME_WIDTH.
  - "T(N)" is the counter value before edge N.
- Priming, per channel i:
  - At the first edge where enable[i]=1 after reset or after enable[i] was 0, load prev[i]<=sig_in[i] and set primed[i].
  - No event is produced at that edge.
- Change detect:
  - At edge N with enable[i]=1, primed[i]=1 and sig_in[i]!=prev[i]: prev[i]<=sig_in[i].
  - If pending[i]=0: set pending[i], pval[i]<=sig_in[i], ptime[i]<=T(N).
  - If pending[i]=1 and not enqueued at edge N: overwrite pval[i] and ptime[i] with the newest, and drop_count+1.
- Arbitration:
  - At each edge, if FIFO not full (registered full flag), the lowest-index channel with pending=1 is pushed {i, pval, ptime} and its pending cleared.
  - At most one push per edge.
  - A channel pushed at edge N can register a new pending change at the same edge N.
- Disable:
  - enable[i]=0 at an edge clears pending[i] and primed[i].
  - Any pending event is discarded without incrementing drop_count.
- Latency:
  - A change sampled at edge N with no contention and FIFO empty is pushed at edge N+1.
  - evt_valid=1 after edge N+1, with evt_time=T(N).
- FIFO:
  - First-word-fall-through; head is shown on evt_* whenever evt_valid=1.
  - Pop at an edge when evt_valid && evt_ready.
  - Push and pop at the same edge are both performed when not full; fifo_level is unchanged.
  - When full, no push occurs even if a pop happens at the same edge. Pending state holds instead.
  - evt_* outputs are stable while evt_valid=1 and evt_ready=0.
- drop_count:
  - Saturates at 2^CNT_WIDTH-1.
  - clear_drops=1 sets it to 0, overriding a simultaneous increment.
- Simultaneous changes on several channels are all captured as pending at the same edge, with the same ptime. They drain in ascending index order, one per edge.
- Only value differences are detected. X/Z compare behaviour is unspecified; the bench drives known values only.

Test Plan:
- Single change: reset, enable=4'b0001, sig0=0 for 2 cycles, then 0x5 at edge 10 → one event {ch0, 0x5, time=9} with evt_valid high after edge 11; fifo_level=1; no event for the priming edge.
- Priority burst: ch0..ch3 all change at the same edge, evt_ready=1 → four events ch0,ch1,ch2,ch3 on consecutive cycles, all with identical evt_time, drop_count=0.
- Coalescing: DEPTH=2, evt_ready=0, ch0 changes 5 times on consecutive edges → FIFO fills with the first two, pending holds the last value, drop_count=2. Raising evt_ready then yields 3 events ending with the final value.
- Backpressure stability: hold evt_ready=0 for 8 cycles with evt_valid=1 → evt_* unchanged. A one-cycle evt_ready pop then decrements fifo_level by 1.
- Disable/clear: pending on ch2, deassert enable[2] → no ch2 event, drop_count unchanged. clear_drops together with a coalesce → drop_count=0.
- Reset mid-stream plus time wrap: TIME_WIDTH=4 and 3 queued events, assert rst_n=0 for one edge → evt_valid=0, fifo_level=0. After release, a change sampled at T=15 followed by one at T=0 reports times 15 then 0.
